// File: rtl/note_scroller.sv
// Song note scroller: fetches note rows from a synchronous pattern ROM and holds each row
// on the matrix for a programmable number of scroll steps.
module note_scroller #(
  parameter int unsigned COLS     = 10,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OFF_W    = 4,
  parameter int unsigned SONG_W   = 2,
  parameter int unsigned ROW_W    = 5,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [SONG_W-1:0]          song_i,
  input  logic                       pause_i,
  input  logic                       abort_i,
  output logic [SONG_W+ROW_W-1:0]    rom_addr_o,
  output logic                       rom_rd_o,
  input  logic [CHANNELS*COLS-1:0]   rom_data_i,
  output logic [CHANNELS*COLS-1:0]   notes_o,
  output logic [OFF_W-1:0]           offset_o,
  output logic                       busy_o,
  output logic                       finish_o
);

  localparam int unsigned DataW = CHANNELS * COLS;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [OFF_W-1:0] OffMax  = '1;
  localparam logic [ROW_W-1:0] RowMax  = '1;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StDone} state_e;

  state_e                    state_q;
  logic [SONG_W-1:0]         song_prev_q;
  logic [SONG_W-1:0]         song_q;
  logic [ROW_W-1:0]          row_q;
  logic [TickW-1:0]          tick_q;
  logic [OFF_W-1:0]          offset_q;
  logic [DataW-1:0]          notes_q;
  logic [SONG_W+ROW_W-1:0]   rom_addr_q;
  logic                      rom_rd_q;
  logic                      finish_q;
  logic                      start;

  assign start = (song_i != '0) && (song_prev_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      song_prev_q <= '0;
      song_q      <= '0;
      row_q       <= '0;
      tick_q      <= '0;
      offset_q    <= '0;
      notes_q     <= '0;
      rom_addr_q  <= '0;
      rom_rd_q    <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      song_prev_q <= song_i;
      rom_rd_q    <= 1'b0;
      finish_q    <= 1'b0;
      // Abort beats every transition, including a start seen in the same idle cycle.
      if (abort_i) begin
        state_q  <= StIdle;
        notes_q  <= '0;
        offset_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              song_q     <= song_i;
              row_q      <= '0;
              rom_addr_q <= {song_i, {ROW_W{1'b0}}};
              rom_rd_q   <= 1'b1;
              state_q    <= StFetch;
            end
          end
          StFetch: state_q <= StLoad;
          StLoad: begin
            if (&rom_data_i) begin
              state_q <= StDone;
            end else begin
              notes_q  <= rom_data_i;
              offset_q <= '0;
              tick_q   <= '0;
              state_q  <= StShift;
            end
          end
          StShift: begin
            if (!pause_i) begin
              if (tick_q == TickMax) begin
                tick_q <= '0;
                if (offset_q != OffMax) begin
                  offset_q <= offset_q + OFF_W'(1);
                end else if (row_q == RowMax) begin
                  state_q <= StDone;
                end else begin
                  // Strobe is issued on entry so the data lands while in StLoad.
                  row_q      <= row_q + ROW_W'(1);
                  rom_addr_q <= {song_q, row_q + ROW_W'(1)};
                  rom_rd_q   <= 1'b1;
                  state_q    <= StFetch;
                end
              end else begin
                tick_q <= tick_q + TickW'(1);
              end
            end
          end
          StDone: begin
            finish_q <= 1'b1;
            notes_q  <= '0;
            offset_q <= '0;
            state_q  <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign rom_rd_o   = rom_rd_q;
  assign notes_o    = notes_q;
  assign offset_o   = offset_q;
  assign busy_o     = (state_q != StIdle);
  assign finish_o   = finish_q;

endmodule

// File: tb/tb_note_scroller.sv
// Randomised self-checking bench for note_scroller: default instance plus a swept-parameter one.
module tb_note_scroller;

  localparam int ROWS = 32;
  localparam int S1 = 16;
  localparam int T1 = 4;
  localparam int S2 = 8;
  localparam int T2 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  song1 = '0;
  logic        pause1 = 1'b0;
  logic        abort1 = 1'b0;
  logic [6:0]  addr1;
  logic        rd1;
  logic [19:0] data1;
  logic [19:0] notes1;
  logic [3:0]  off1;
  logic        busy1;
  logic        fin1;

  logic [1:0]  song2 = '0;
  logic        pause2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [6:0]  addr2;
  logic        rd2;
  logic [47:0] data2;
  logic [47:0] notes2;
  logic [2:0]  off2;
  logic        busy2;
  logic        fin2;

  logic [19:0] rom1 [0:127];
  logic [47:0] rom2 [0:127];

  int passed = 0;
  int total = 0;

  note_scroller u_dut (
    .clk_i(clk), .rst_ni(rst_n), .song_i(song1), .pause_i(pause1), .abort_i(abort1),
    .rom_addr_o(addr1), .rom_rd_o(rd1), .rom_data_i(data1), .notes_o(notes1),
    .offset_o(off1), .busy_o(busy1), .finish_o(fin1)
  );

  note_scroller #(
    .COLS(16), .CHANNELS(3), .OFF_W(3), .SONG_W(2), .ROW_W(5), .TICK_DIV(1)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .song_i(song2), .pause_i(pause2), .abort_i(abort2),
    .rom_addr_o(addr2), .rom_rd_o(rd2), .rom_data_i(data2), .notes_o(notes2),
    .offset_o(off2), .busy_o(busy2), .finish_o(fin2)
  );

  always #5 clk = ~clk;

  // Synchronous pattern ROMs: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd1) data1 <= rom1[addr1];
    if (rd2) data2 <= rom2[addr2];
  end

  // Reference timeline: j = clock edges since the edge that sampled start. Each row takes
  // one fetch cycle, one load cycle, then steps*div scroll cycles. m = marker row (>=ROWS: none).
  function automatic void model(input int j, input int steps, input int div, input int m,
                                output logic busy, output logic fin, output logic rd,
                                output int raddr, output int off, output int nsel);
    int plen;
    int jd;
    int r;
    int p;
    plen = 2 + steps * div;
    jd = (m >= ROWS) ? ROWS * plen : m * plen + 2;
    busy = 1'b0; fin = 1'b0; rd = 1'b0; raddr = 0; off = 0; nsel = -1;
    if (j > jd) begin
      fin = (j == jd + 1);
    end else if (j == jd) begin
      busy = 1'b1;
      nsel = (m >= ROWS) ? ROWS - 1 : m - 1;
      off = (nsel >= 0) ? steps - 1 : 0;
    end else if (j >= 0) begin
      busy = 1'b1;
      r = j / plen;
      p = j % plen;
      if (p < 2) begin
        rd = (p == 0);
        raddr = r;
        nsel = r - 1;
        off = (r > 0) ? steps - 1 : 0;
      end else begin
        nsel = r;
        off = (p - 2) / div;
      end
    end
  endfunction

  task automatic run_song1(input int s, input int m, input int jp, input int ja, input bit hold);
    int jd;
    int jend;
    int je;
    logic eb, ef, er;
    int ea, eo, en;
    logic [33:0] exp_v;
    logic [33:0] obs_v;
    logic [19:0] v;
    for (int r = 0; r < ROWS; r++) begin
      v = 20'($urandom);
      if (&v) v[0] = 1'b0;
      rom1[s * ROWS + r] = (r == m) ? '1 : v;
    end
    song1 = '0;
    @(posedge clk); #1;
    song1 = 2'(s);
    jd = (m >= ROWS) ? ROWS * (2 + S1 * T1) : m * (2 + S1 * T1) + 2;
    jend = (ja >= 0) ? ja + 8 : jd + 4 + ((jp >= 0) ? 10 : 0);
    for (int j = 0; j <= jend; j++) begin
      @(posedge clk); #1;
      if (!hold) song1 = '0;
      je = j;
      if (jp >= 0 && j > jp) je = j - (((j - jp) > 10) ? 10 : (j - jp));
      model(je, S1, T1, m, eb, ef, er, ea, eo, en);
      if (ja >= 0 && j > ja) begin
        eb = 1'b0; ef = 1'b0; er = 1'b0; eo = 0; en = -1;
      end
      exp_v = {eb, ef, er, er ? 7'(s * ROWS + ea) : 7'd0, 4'(eo),
               (en >= 0) ? rom1[s * ROWS + en] : 20'd0};
      obs_v = {busy1, fin1, rd1, er ? addr1 : 7'd0, off1, notes1};
      total++;
      if (obs_v !== exp_v)
        $display("FAIL song1 s=%0d m=%0d j=%0d got=%h exp=%h", s, m, j, obs_v, exp_v);
      else
        passed++;
      pause1 = (jp >= 0 && j >= jp && j < jp + 10);
      abort1 = (ja >= 0 && j == ja);
    end
    pause1 = 1'b0;
    abort1 = 1'b0;
  endtask

  task automatic run_song2(input int s, input int m);
    int jd;
    logic eb, ef, er;
    int ea, eo, en;
    logic [60:0] exp_v;
    logic [60:0] obs_v;
    logic [47:0] v;
    for (int r = 0; r < ROWS; r++) begin
      v = 48'({$urandom(), $urandom()});
      if (&v) v[0] = 1'b0;
      rom2[s * ROWS + r] = (r == m) ? '1 : v;
    end
    song2 = '0;
    @(posedge clk); #1;
    song2 = 2'(s);
    jd = (m >= ROWS) ? ROWS * (2 + S2 * T2) : m * (2 + S2 * T2) + 2;
    for (int j = 0; j <= jd + 4; j++) begin
      @(posedge clk); #1;
      song2 = '0;
      model(j, S2, T2, m, eb, ef, er, ea, eo, en);
      exp_v = {eb, ef, er, er ? 7'(s * ROWS + ea) : 7'd0, 3'(eo),
               (en >= 0) ? rom2[s * ROWS + en] : 48'd0};
      obs_v = {busy2, fin2, rd2, er ? addr2 : 7'd0, off2, notes2};
      total++;
      if (obs_v !== exp_v)
        $display("FAIL song2 s=%0d m=%0d j=%0d got=%h exp=%h", s, m, j, obs_v, exp_v);
      else
        passed++;
    end
  endtask

  task automatic test_reset();
    logic [33:0] z1;
    logic [60:0] z2;
    #13;
    z1 = {busy1, fin1, rd1, addr1, off1, notes1};
    z2 = {busy2, fin2, rd2, addr2, off2, notes2};
    total++;
    if (z1 !== '0 || z2 !== '0) $display("FAIL reset_hold got=%h/%h exp=0", z1, z2);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      z1 = {busy1, fin1, rd1, addr1, off1, notes1};
      z2 = {busy2, fin2, rd2, addr2, off2, notes2};
      total++;
      if (z1 !== '0 || z2 !== '0) $display("FAIL reset_idle got=%h/%h exp=0", z1, z2);
      else passed++;
    end
  endtask

  task automatic test_abort_idle();
    song1 = '0;
    @(posedge clk); #1;
    song1 = 2'd1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy1 !== 1'b0 || rd1 !== 1'b0) $display("FAIL abort_idle busy=%b rd=%b exp=0/0",
                                                    busy1, rd1);
      else passed++;
      @(posedge clk); #1;
    end
    song1 = '0;
  endtask

  task automatic test_async_reset();
    logic [19:0] v;
    logic [33:0] z1;
    for (int r = 0; r < ROWS; r++) begin
      v = 20'($urandom);
      if (&v) v[0] = 1'b0;
      rom1[ROWS + r] = v;
    end
    song1 = '0;
    @(posedge clk); #1;
    song1 = 2'd1;
    @(posedge clk); #1;
    song1 = '0;
    repeat (80) @(posedge clk);
    #1;
    total++;
    if (busy1 !== 1'b1 || off1 === 4'd0) $display("FAIL async_pre busy=%b off=%0d exp=1/>0",
                                                   busy1, off1);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    z1 = {busy1, fin1, rd1, addr1, off1, notes1};
    total++;
    if (z1 !== '0) $display("FAIL async_reset got=%h exp=0", z1);
    else passed++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s;
    int m;
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(1, 3);
      m = $urandom_range(0, 6);
      run_song1(s, m, -1, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    run_song1(1, ROWS, -1, -1, 1'b0);          // full 32-row song
    run_song1(2, 3, -1, -1, 1'b0);             // end marker in row 3
    run_song1(3, 0, -1, -1, 1'b0);             // end marker in row 0
    run_song1(1, 4, 2 + 5 * T1 + 1, -1, 1'b0); // pause at offset 5
    run_song1(2, ROWS, -1, 2 * (2 + S1 * T1) + 2 + 7 * T1 + 2, 1'b0); // abort row 2 off 7
    run_song1(2, 2, -1, -1, 1'b0);             // restart after abort
    run_song1(1, 1, -1, -1, 1'b1);             // song held through done: no restart
    run_song1(1, 2, -1, -1, 1'b0);             // drop and re-raise restarts
    test_abort_idle();
    test_async_reset();
    test_back_to_back();
    run_song2(1, ROWS);
    run_song2(3, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Parametrised successor to the fixed-size song loader that feeds the LED matrix note display.
- On a song request, fetches note rows from a synchronous pattern ROM, one row at a time, and presents each row for a programmable number of scroll steps.
- Generalised over column count, colour-channel count, scroll depth and step rate.
- Adds pause, abort, early end-of-song marker and a busy flag.
- Sits between the song-select logic and the matrix row driver.

Parameters:
- COLS, 10, note columns per channel.
- CHANNELS, 2, colour planes (R,G,...), packed channel 0 in LSBs.
- OFF_W, 4, offset width; STEPS = 2**OFF_W scroll steps per row.
- SONG_W, 2, song-select width; value 0 means "no song".
- ROW_W, 5, row index width; ROWS = 2**ROW_W max rows per song.
- TICK_DIV, 4, clock cycles per scroll step (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; the clock is single, and reset is asynchronous and active-low (0 = reset).
- song  in  SONG_W  song request; start on 0 -> nonzero transition.
- pause  in  1  freeze scrolling while high.
- abort  in  1  synchronous cancel, any state.
- rom_addr  out  SONG_W+ROW_W  {song_q,row} ROM address.
- rom_rd  out  1  ROM read strobe.
- rom_data  in  CHANNELS*COLS  ROM row data, valid the cycle after rom_rd.
- notes  out  CHANNELS*COLS  current displayed row.
- offset  out  OFF_W  scroll position within current row.
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle pulse at song end.

Behaviour:
- Reset (rst=0, async): state IDLE. notes=0, offset=0, rom_addr=0, rom_rd=0, busy=0, finish=0. song_prev=0, tick=0, row=0.
- song_prev is registered every cycle. start = (song!=0) && (song_prev==0). start is honoured only in IDLE; song changes in other states are ignored.
- IDLE: on start, latch song_q=song, row=0, go to FETCH.
- FETCH (1 cycle):
  - rom_rd=1, rom_addr={song_q,row}; go to LOAD.
  - notes/offset hold their previous values.
- LOAD (1 cycle), rom_data valid:
  - If rom_data is all ones (end marker), go to DONE; notes is not updated.
  - Otherwise notes=rom_data, offset=0, tick=0, go to SHIFT.
- SHIFT:
  - If pause=0, tick increments each cycle. If pause=1, tick and offset are frozen.
  - When tick==TICK_DIV-1 and not paused: tick=0.
    - If offset<STEPS-1, offset+1.
    - Else if row==ROWS-1, go to DONE.
    - Else row+1, go to FETCH. offset stays STEPS-1 through FETCH/LOAD.
- DONE (1 cycle): finish=1, notes=0, offset=0, go to IDLE.
- Row period = 2 + STEPS*TICK_DIV cycles unpaused. Defaults give 66 cycles.
- pause has no effect in FETCH/LOAD/DONE.
- abort=1 in any non-IDLE state: next edge goes to IDLE, notes=0, offset=0, rom_rd=0, with no finish pulse. abort has priority over all other transitions.
- A song held nonzero across DONE does not restart; a new 0 -> nonzero edge is required.
- abort and start in the same IDLE cycle: abort wins, remains IDLE.
- A ROM end marker in row 0 goes straight to DONE: finish pulses 3 cycles after start is sampled.

Test Plan:
- Reset, song 0->1 for 1 cycle, ROM rows 0..31 non-marker, defaults -> rom_addr=7'b01_00000 on first FETCH. offset steps 0..15 every 4 cycles. 32 rows x 66 cycles then finish pulse exactly 1 cycle. busy falls with finish.
- song=2, row 3 of song 2 = all ones -> after rows 0-2 are scrolled, DONE. finish at cycle 3*66+3 after start. notes=0.
- pause high for 10 cycles mid-SHIFT at offset=5 -> offset holds 5, tick holds. Resumes with same remaining tick count; total song time +10 cycles.
- abort at offset=7, row=2 -> next cycle IDLE, busy=0, notes=0, finish never asserts. A new song edge restarts from row 0.
- song held at 1 through DONE -> no restart. Drop song to 0 then back to 1 -> restart.
- Async reset asserted mid-SHIFT, between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
- Parameter sweep COLS=16, CHANNELS=3, OFF_W=3, TICK_DIV=1 -> notes 48 bits wide, offset wraps at 7, row period 10 cycles.
